// File: rtl/param_piso_serializer.sv
// Parallel-in/serial-out serializer with a one-entry holding buffer so the next
// word can be accepted while the current one shifts; shifting is gated by ss_n.
module param_piso_serializer #(
   parameter int WIDTH      = 16,
   parameter bit MSB_FIRST  = 1'b0,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ss_n,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             word_done,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_WAIT = 2'b10,
      ST_SEND = 2'b11
   } state_t;

   state_t           state_q,     state_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] hold_q,      hold_d;
   logic [WIDTH-1:0] shift_q,     shift_d;
   logic [CW-1:0]    cnt_q,       cnt_d;
   logic             word_done_q, word_done_d;

   logic             shift_en;
   logic             out_bit;
   logic [WIDTH-1:0] shifted;

   // The bit on the line is always the one nearest the output end of the register.
   assign out_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
   assign shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

   assign shift_en     = (state_q == ST_SEND) && !ss_n;
   assign serial_valid = shift_en;
   assign serial_out   = shift_en ? out_bit : IDLE_LEVEL;
   assign load_ready   = !hold_full_q;
   assign word_done    = word_done_q;
   assign busy         = (state_q != ST_IDLE) || hold_full_q;
   assign state_dbg    = state_q;

   always_comb begin
      state_d     = state_q;
      hold_full_d = hold_full_q;
      hold_d      = hold_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      word_done_d = 1'b0;

      // Only an empty buffer can accept, so this never collides with the LOAD clear.
      if (load_valid && !hold_full_q) begin
         hold_full_d = 1'b1;
         hold_d      = data_in;
      end

      case (state_q)
         ST_IDLE: begin
            if (hold_full_q) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            shift_d     = hold_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
            state_d     = ST_WAIT;
         end
         ST_WAIT: begin
            if (!ss_n) begin
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (shift_en) begin
               shift_d = shifted;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  word_done_d = 1'b1;
                  state_d     = hold_full_q ? ST_LOAD : ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         hold_full_q <= 1'b0;
         hold_q      <= '0;
         shift_q     <= '0;
         cnt_q       <= '0;
         word_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_full_q <= hold_full_d;
         hold_q      <= hold_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         word_done_q <= word_done_d;
      end
   end

endmodule

// File: tb/tb_param_piso_serializer.sv
// Scoreboard bench for param_piso_serializer: a 16-bit LSB-first instance and an
// 8-bit MSB-first instance; expected bit streams are queued at issue time.
module tb_param_piso_serializer;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   // Instance A: WIDTH=16, LSB first
   logic        lv_a  = 1'b0;
   logic        lr_a;
   logic [15:0] din_a = '0;
   logic        ssn_a = 1'b0;
   logic        so_a, sv_a, wd_a, busy_a;
   logic [1:0]  st_a;

   // Instance B: WIDTH=8, MSB first
   logic        lv_b  = 1'b0;
   logic        lr_b;
   logic [7:0]  din_b = '0;
   logic        ssn_b = 1'b0;
   logic        so_b, sv_b, wd_b, busy_b;
   logic [1:0]  st_b;

   param_piso_serializer #(.WIDTH(16), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_a (
      .clock(clk), .resetn(resetn), .load_valid(lv_a), .load_ready(lr_a), .data_in(din_a),
      .ss_n(ssn_a), .serial_out(so_a), .serial_valid(sv_a), .word_done(wd_a), .busy(busy_a),
      .state_dbg(st_a));

   param_piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_b (
      .clock(clk), .resetn(resetn), .load_valid(lv_b), .load_ready(lr_b), .data_in(din_b),
      .ss_n(ssn_b), .serial_out(so_b), .serial_valid(sv_b), .word_done(wd_b), .busy(busy_b),
      .state_dbg(st_b));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int ss_mode = 0;   // 0: ss_n low, 1: ss_n high, 2: random

   // Expected serial streams; the bench writes entries and wr_*, the monitor owns rd_*.
   bit exp_bit_a[4096], exp_first_a[4096], exp_last_a[4096];
   bit exp_bit_b[1024], exp_first_b[1024], exp_last_b[1024];
   int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

   bit exp_done_a = 1'b0, exp_done_b = 1'b0;
   int done_cnt_a = 0, done_cnt_b = 0;
   int bits_in_word_a = 0, bits_in_word_b = 0;
   int word_len_a = 0, word_len_b = 0;
   int first_cyc_a = 0, last_cyc_a = -100, gap_a = 0, span_a = 0;
   int first_cyc_b = 0;
   int hs_cyc_a = 0, hs_cyc_b = 0;

   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(posedge clk);
      #1;
      if (ss_mode == 2) ssn_a = ($urandom_range(0, 9) < 3);
      else              ssn_a = (ss_mode == 1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!resetn) begin
         rd_a = wr_a;
         rd_b = wr_b;
         exp_done_a = 1'b0;
         exp_done_b = 1'b0;
         bits_in_word_a = 0;
         bits_in_word_b = 0;
      end else begin
         chk("word_done_a", wd_a, exp_done_a);
         exp_done_a = 1'b0;
         if (sv_a) begin
            chk("bit_pending_a", rd_a < wr_a, 1);
            if (rd_a < wr_a) begin
               chk("serial_out_a", so_a, exp_bit_a[rd_a]);
               if (exp_first_a[rd_a]) begin
                  gap_a = cyc - last_cyc_a;
                  first_cyc_a = cyc;
                  bits_in_word_a = 0;
               end
               bits_in_word_a++;
               if (exp_last_a[rd_a]) begin
                  exp_done_a = 1'b1;
                  last_cyc_a = cyc;
                  span_a = cyc - first_cyc_a;
                  word_len_a = bits_in_word_a;
               end
               rd_a++;
            end
         end else begin
            chk("idle_level_a", so_a, 0);
         end
         if (wd_a) done_cnt_a++;

         chk("word_done_b", wd_b, exp_done_b);
         exp_done_b = 1'b0;
         if (sv_b) begin
            chk("bit_pending_b", rd_b < wr_b, 1);
            if (rd_b < wr_b) begin
               chk("serial_out_b", so_b, exp_bit_b[rd_b]);
               if (exp_first_b[rd_b]) begin
                  first_cyc_b = cyc;
                  bits_in_word_b = 0;
               end
               bits_in_word_b++;
               if (exp_last_b[rd_b]) begin
                  exp_done_b = 1'b1;
                  word_len_b = bits_in_word_b;
               end
               rd_b++;
            end
         end else begin
            chk("idle_level_b", so_b, 0);
         end
         if (wd_b) done_cnt_b++;
      end
   end

   // Offer a word, queue its expected bit order, and return just after the handshake edge.
   task automatic send_a(input logic [15:0] w);
      int n = 0;
      lv_a  = 1'b1;
      din_a = w;
      while (!lr_a && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("load_ready_timeout_a", lr_a, 1);
      for (int i = 0; i < 16; i++) begin
         exp_bit_a[wr_a + i]   = w[i];
         exp_first_a[wr_a + i] = (i == 0);
         exp_last_a[wr_a + i]  = (i == 15);
      end
      wr_a += 16;
      @(posedge clk);
      #1;
      hs_cyc_a = cyc;
      lv_a  = 1'b0;
      din_a = 16'($urandom);
   endtask

   task automatic send_b(input logic [7:0] w);
      int n = 0;
      lv_b  = 1'b1;
      din_b = w;
      while (!lr_b && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("load_ready_timeout_b", lr_b, 1);
      for (int i = 0; i < 8; i++) begin
         exp_bit_b[wr_b + i]   = w[7 - i];
         exp_first_b[wr_b + i] = (i == 0);
         exp_last_b[wr_b + i]  = (i == 7);
      end
      wr_b += 8;
      @(posedge clk);
      #1;
      hs_cyc_b = cyc;
      lv_b  = 1'b0;
      din_b = 8'($urandom);
   endtask

   task automatic wait_done_a(input int target);
      int n = 0;
      while (done_cnt_a < target && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("done_timeout_a", done_cnt_a >= target, 1);
   endtask

   task automatic wait_done_b(input int target);
      int n = 0;
      while (done_cnt_b < target && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("done_timeout_b", done_cnt_b >= target, 1);
   endtask

   task automatic wait_bits_a(input int k);
      int n = 0;
      while (bits_in_word_a != k && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("bits_timeout_a", bits_in_word_a, k);
   endtask

   task automatic wait_state_a(input logic [1:0] s);
      int n = 0;
      while (st_a !== s && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("state_timeout_a", st_a, s);
   endtask

   initial begin
      int base;
      int n;

      // Reset values
      #12;
      chk("rst_load_ready_a", lr_a, 1);
      chk("rst_valid_a", sv_a, 0);
      chk("rst_serial_out_a", so_a, 0);
      chk("rst_word_done_a", wd_a, 0);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_state_a", st_a, 0);
      chk("rst_load_ready_b", lr_b, 1);
      chk("rst_busy_b", busy_b, 0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      #1;

      // 0xA5C3 LSB first: latency 3 cycles, one pulse, back to idle
      base = done_cnt_a;
      send_a(16'hA5C3);
      chk("busy_after_load_a", busy_a, 1);
      wait_done_a(base + 1);
      chk("latency_a", first_cyc_a - hs_cyc_a, 3);
      chk("word_len_a5c3", word_len_a, 16);
      chk("idle_after_a5c3", st_a, 0);
      chk("not_busy_after_a5c3", busy_a, 0);
      repeat (4) @(negedge clk);
      #1;
      chk("single_pulse_a5c3", done_cnt_a - base, 1);

      // 0x96 MSB first on the 8-bit instance
      base = done_cnt_b;
      send_b(8'h96);
      wait_done_b(base + 1);
      chk("latency_b", first_cyc_b - hs_cyc_b, 3);
      chk("word_len_96", word_len_b, 8);
      repeat (4) @(negedge clk);
      #1;
      chk("single_pulse_96", done_cnt_b - base, 1);

      // Second word buffered during SEND goes out after exactly two idle cycles
      base = done_cnt_a;
      send_a(16'h0001);
      wait_state_a(2'b11);
      send_a(16'h8000);
      chk("ready_low_after_2nd", lr_a, 0);
      wait_done_a(base + 2);
      chk("b2b_gap", gap_a, 3);
      repeat (4) @(negedge clk);
      #1;
      chk("b2b_pulses", done_cnt_a - base, 2);

      // ss_n pause after the 5th bit stretches the word by 3 cycles
      base = done_cnt_a;
      send_a(16'hFFFF);
      wait_bits_a(5);
      ss_mode = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      ss_mode = 0;
      wait_done_a(base + 1);
      chk("pause_span", span_a, 18);
      chk("pause_word_len", word_len_a, 16);

      // Asynchronous reset mid-word discards it
      send_a(16'h1234);
      wait_bits_a(7);
      resetn = 1'b0;
      #1;
      chk("arst_load_ready", lr_a, 1);
      chk("arst_valid", sv_a, 0);
      chk("arst_serial_out", so_a, 0);
      chk("arst_word_done", wd_a, 0);
      chk("arst_busy", busy_a, 0);
      chk("arst_state", st_a, 0);
      @(negedge clk);
      #1;
      resetn = 1'b1;
      base = done_cnt_a;
      send_a(16'hBEEF);
      wait_done_a(base + 1);
      chk("post_reset_len", word_len_a, 16);
      chk("post_reset_span", span_a, 15);

      // Randomized traffic with random ss_n on A, plain traffic on B
      ss_mode = 2;
      for (int i = 0; i < 30; i++) begin
         send_a(16'($urandom));
         repeat ($urandom_range(0, 20)) @(posedge clk);
         #1;
      end
      for (int i = 0; i < 10; i++) begin
         send_b(8'($urandom));
         repeat ($urandom_range(0, 6)) @(posedge clk);
         #1;
      end
      n = 0;
      while ((rd_a != wr_a || rd_b != wr_b) && n < 5000) begin
         @(negedge clk);
         #1;
         n++;
      end
      ss_mode = 0;
      chk("drained_a", rd_a, wr_a);
      chk("drained_b", rd_b, wr_b);
      repeat (4) @(negedge clk);
      #1;
      chk("final_idle_a", busy_a, 0);
      chk("final_idle_b", busy_b, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
